// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-look-ahead adder/subtractor with valid/ready handshake and ALU flags.
// WIDTH is cut into STAGES segments; the segment carry and the untouched upper operands ride a register chain.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SEG = WIDTH / STAGES;

  if ((STAGES < 1) || (BLOCK < 1) || ((WIDTH % (STAGES * BLOCK)) != 0)) begin : g_bad_cfg
    $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES*BLOCK");
  end

  // Group generate/propagate per BLOCK bits, with group carries chained look-ahead style.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] g, p, s;
    logic           cg, cb, gg, pg;
    g  = x & y;
    p  = x ^ y;
    s  = '0;
    cg = ci;
    for (int j = 0; j < SEG / BLOCK; j++) begin
      gg = 1'b0;
      pg = 1'b1;
      cb = cg;
      for (int i = 0; i < BLOCK; i++) begin
        s[j*BLOCK+i] = p[j*BLOCK+i] ^ cb;
        cb = g[j*BLOCK+i] | (p[j*BLOCK+i] & cb);
        gg = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg);
        pg = pg & p[j*BLOCK+i];
      end
      cg = gg | (pg & cg);
    end
    return {cg, s};
  endfunction

  logic              stall;
  logic [STAGES-1:0] v_d, v_q;
  logic [WIDTH-1:0]  b_eff;

  assign b_eff     = b ^ {WIDTH{mode}};
  assign out_valid = v_q[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  always_comb begin
    v_d = v_q;
    if (!stall) begin
      v_d[0] = in_valid;
      for (int k = 1; k < STAGES; k++) v_d[k] = v_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

  // acc holds finished sum bits below the stage boundary and operand A bits above it.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int BW = WIDTH - k * SEG;

    logic [WIDTH-1:0] acc_in, acc_d, acc_q;
    logic [BW-1:0]    b_in;
    logic             ci, c_d, c_q;
    logic [SEG:0]     r;

    if (k == 0) begin : g_head
      assign acc_in = a;
      assign b_in   = b_eff;
      assign ci     = cin;
    end else begin : g_link
      assign acc_in = g_stg[k-1].acc_q;
      assign b_in   = g_stg[k-1].g_fwd.b_q;
      assign ci     = g_stg[k-1].c_q;
    end

    assign r = cla_seg(acc_in[k*SEG +: SEG], b_in[SEG-1:0], ci);

    always_comb begin
      acc_d = acc_q;
      c_d   = c_q;
      if (!stall) begin
        acc_d                 = acc_in;
        acc_d[k*SEG +: SEG]   = r[SEG-1:0];
        c_d                   = r[SEG];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
        c_q   <= 1'b0;
      end else begin
        acc_q <= acc_d;
        c_q   <= c_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [BW-SEG-1:0] b_d, b_q;

      always_comb begin
        b_d = b_q;
        if (!stall) b_d = b_in[BW-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) b_q <= '0;
        else     b_q <= b_d;
      end
    end

    if (k == STAGES - 1) begin : g_flag
      logic ovf_d, ovf_q;

      // Carry into the MSB recovered from its sum bit: x ^ y ^ s.
      always_comb begin
        ovf_d = ovf_q;
        if (!stall) ovf_d = (acc_in[WIDTH-1] ^ b_in[SEG-1] ^ r[SEG-1]) ^ r[SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
      end
    end
  end

  assign sum      = g_stg[STAGES-1].acc_q;
  assign cout     = g_stg[STAGES-1].c_q;
  assign overflow = g_stg[STAGES-1].g_flag.ovf_q;
  assign zero     = (sum == '0);
  assign negative = sum[WIDTH-1];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed and streaming checks for pipelined_cla_addsub at WIDTH=32, STAGES=2.
// Observed word is packed {overflow, cout, zero, negative, sum}.
module tb_pipelined_cla_addsub;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, mode, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cout, overflow, zero, negative;

  int n_chk = 0;
  int n_bad = 0;

  logic [35:0] exp_q[$];

  pipelined_cla_addsub #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] obs();
    return {overflow, cout, zero, negative, sum};
  endfunction

  function automatic logic [35:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic md, input logic ci);
    logic [W-1:0] by;
    logic [W:0]   r;
    logic         ov;
    by = y ^ {W{md}};
    r  = {1'b0, x} + {1'b0, by} + {{W{1'b0}}, ci};
    ov = (x[W-1] == by[W-1]) && (r[W-1] != x[W-1]);
    return {ov, r[W], (r[W-1:0] == '0), r[W-1], r[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated op: latency must be exactly two edges after accept.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic md, input logic ci, input logic [35:0] exp);
    a = x; b = y; mode = md; cin = ci;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~x; b = ~y; mode = ~md; cin = ~ci;
    chk({tag, "_early"}, out_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk(tag, obs(), exp);
  endtask

  task automatic stream(input string tag, input int n_ops, input bit rnd, input int max_cyc);
    int          sent, got, cyc;
    bit          was_stall;
    logic [35:0] prev;
    sent = 0; got = 0; cyc = 0; was_stall = 0; prev = '0;
    exp_q.delete();
    while (got < n_ops && cyc < max_cyc) begin
      a = $urandom(); b = $urandom();
      if (rnd) begin
        in_valid  = (sent < n_ops) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        mode      = $urandom_range(0, 1);
        cin       = $urandom_range(0, 1);
      end else begin
        in_valid  = (sent < n_ops);
        out_ready = !(cyc >= 4 && cyc <= 6);
        mode      = 1'b0;
        cin       = 1'b0;
      end
      @(negedge clk);
      if (!rnd) chk({tag, "_in_ready"}, in_ready, !(cyc >= 4 && cyc <= 6));
      if (was_stall) chk({tag, "_hold"}, obs(), prev);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk({tag, "_extra"}, out_valid, 1'b0);
        else begin
          chk(tag, obs(), exp_q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, mode, cin));
        sent++;
      end
      was_stall = out_valid && !out_ready;
      prev      = obs();
      tick();
      cyc++;
    end
    chk({tag, "_count"}, got, n_ops);
    chk({tag, "_left"}, exp_q.size(), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; mode = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_flags", obs(), 36'h2_0000_0000);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);

    run_op("add_boundary", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 36'h0_0001_0000);
    run_op("sub_neg",      32'd5,         32'd7,         1'b1, 1'b1, 36'h1_FFFF_FFFE);
    run_op("sub_zero",     32'd7,         32'd7,         1'b1, 1'b1, 36'h6_0000_0000);
    run_op("add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 36'h9_8000_0000);
    run_op("add_wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 36'h6_0000_0000);
    run_op("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 36'hC_7FFF_FFFF);
    run_op("add_cin",      32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 36'h0_1234_5679);
    tick();

    stream("bp", 8, 1'b0, 40);

    // Two ops in flight, result held by back-pressure, then reset.
    a = 32'd1; b = 32'd2; mode = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    a = 32'd3; b = 32'd4;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    chk("rst_inflight", out_valid, 1'b1);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_flags", obs(), 36'h2_0000_0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_emit", out_valid, 1'b0);
    end
    run_op("post_reset", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 36'h0_0000_0030);
    tick();

    stream("rand", 3000, 1'b1, 20000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
